// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN feature-memory subsystem: arbiter states,
// requester indices and default feature-memory geometry.
package cnn_pkg;

  localparam int FM_AW = 12;
  localparam int FM_DW = 32;

  localparam int REQ_FETCH = 0;
  localparam int REQ_LOAD  = 1;
  localparam int REQ_WB    = 2;
  localparam int REQ_HOST  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_LOCK  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: selects the first set request at or after ptr_i,
// wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[j]) begin
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/feature_mem_arbiter.sv
// Round-robin arbiter with lockable bursts in front of a single-port feature
// SRAM (1-cycle read latency); read data is routed back to the requester.
module feature_mem_arbiter
  import cnn_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = FM_AW,
  parameter int DW       = FM_DW,
  parameter int MAX_LOCK = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ-1:0]   req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_e      state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   owner_q;
  logic [CW-1:0]   lock_cnt_q;
  logic [NREQ-1:0] rsp_valid_q;

  logic [NREQ-1:0] rr_grant;
  logic [IW-1:0]   rr_idx;
  logic            rr_any;

  logic [NREQ-1:0] ready_d;
  logic [IW-1:0]   gnt_idx;
  logic            accept;
  logic            gnt_we;
  logic            gnt_lock;
  logic [IW-1:0]   ptr_d;
  logic [CW-1:0]   lock_cnt_d;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .any_o   (rr_any)
  );

  // While locked only the owner can be accepted; otherwise the picker decides.
  always_comb begin
    ready_d = '0;
    gnt_idx = rr_idx;
    if (!reset) begin
      if (state_q == ST_LOCK) begin
        gnt_idx          = owner_q;
        ready_d[owner_q] = req_valid[owner_q];
      end else if (rr_any) begin
        ready_d = rr_grant;
      end
    end
  end

  assign accept     = |ready_d;
  assign gnt_we     = req_we[gnt_idx];
  assign gnt_lock   = req_lock[gnt_idx];
  assign ptr_d      = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
  assign lock_cnt_d = lock_cnt_q + CW'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      lock_cnt_q  <= '0;
      rsp_valid_q <= '0;
    end else begin
      rsp_valid_q <= (accept && !gnt_we) ? ready_d : '0;
      unique case (state_q)
        ST_IDLE, ST_GRANT: begin
          if (accept) begin
            ptr_q <= ptr_d;
            if (gnt_lock && (MAX_LOCK > 1)) begin
              state_q    <= ST_LOCK;
              owner_q    <= gnt_idx;
              lock_cnt_q <= CW'(1);
            end else begin
              state_q <= ST_GRANT;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LOCK: begin
          lock_cnt_q <= lock_cnt_d;
          // Leave on a final beat, a dropped request, or the hold limit;
          // the pointer always moves past the owner so others go next.
          if (!accept || !gnt_lock || (lock_cnt_d >= CW'(MAX_LOCK))) begin
            state_q    <= ST_GRANT;
            ptr_q      <= ptr_d;
            lock_cnt_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Responses are masked during reset so a read accepted just before it
  // never surfaces.
  assign req_ready = ready_d;
  assign rsp_valid = reset ? '0 : rsp_valid_q;
  assign rsp_data  = (!reset && (|rsp_valid_q)) ? mem_rdata : '0;

  assign mem_en    = accept;
  assign mem_we    = accept & gnt_we;
  assign mem_addr  = accept ? req_addr[int'(gnt_idx)*AW +: AW] : '0;
  assign mem_wdata = (accept && gnt_we) ? req_wdata[int'(gnt_idx)*DW +: DW] : '0;

endmodule

// File: tb/tb_feature_mem_arbiter.sv
// Directed bench for feature_mem_arbiter: default instance plus a
// MAX_LOCK=3 instance for the lock-timeout case, each with its own SRAM model.
module tb_feature_mem_arbiter;
  import cnn_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 12;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_we;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;

  logic [NREQ-1:0] ready_a, rsp_valid_a, ready_t, rsp_valid_t;
  logic [DW-1:0]   rsp_data_a, rsp_data_t;
  logic            mem_en_a, mem_we_a, mem_en_t, mem_we_t;
  logic [AW-1:0]   mem_addr_a, mem_addr_t;
  logic [DW-1:0]   mem_wdata_a, mem_wdata_t, mem_rdata_a, mem_rdata_t;

  logic [DW-1:0] mem_a [0:4095];
  logic [DW-1:0] mem_t [0:4095];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  feature_mem_arbiter dut_a (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (ready_a),
    .rsp_valid (rsp_valid_a),
    .rsp_data  (rsp_data_a),
    .mem_en    (mem_en_a),
    .mem_we    (mem_we_a),
    .mem_addr  (mem_addr_a),
    .mem_wdata (mem_wdata_a),
    .mem_rdata (mem_rdata_a)
  );

  feature_mem_arbiter #(.MAX_LOCK(3)) dut_t (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (ready_t),
    .rsp_valid (rsp_valid_t),
    .rsp_data  (rsp_data_t),
    .mem_en    (mem_en_t),
    .mem_we    (mem_we_t),
    .mem_addr  (mem_addr_t),
    .mem_wdata (mem_wdata_t),
    .mem_rdata (mem_rdata_t)
  );

  always @(posedge clk) begin
    if (mem_en_a) begin
      if (mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
      else          mem_rdata_a       <= mem_a[mem_addr_a];
    end
    if (mem_en_t) begin
      if (mem_we_t) mem_t[mem_addr_t] <= mem_wdata_t;
      else          mem_rdata_t       <= mem_t[mem_addr_t];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_we[i]             = we;
    req_lock[i]           = lk;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic idle_all();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
  endtask

  initial begin
    mem_a[12'h040] = 32'hDEADBEEF;
    mem_a[12'h000] = 32'h11111111;
    mem_a[12'h001] = 32'h22222222;
    mem_a[12'h018] = 32'h33333333;
    mem_a[12'h019] = 32'h44444444;
    for (int i = 0; i < 4; i++) mem_a[12'h010 + i] = 32'hC0DE0000 + i;
    mem_t[12'h020] = 32'hCAFEF00D;

    req_addr  = '0;
    req_wdata = '0;
    idle_all();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 1'b0, AW'(12'h010 + i), '0);
    #1;
    check("rst_ready", 32'(ready_a), 32'h0);
    check("rst_mem_en", 32'(mem_en_a), 32'h0);
    cyc();
    cyc();
    check("rst_rsp_valid", 32'(rsp_valid_a), 32'h0);
    check("rst_rsp_data", rsp_data_a, 32'h0);
    check("rst_state", 32'(dut_a.state_q), 32'(ST_IDLE));

    // Contention: all four valid from ptr=0, reads back-to-back
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("cont_ready_%0d", k), 32'(ready_a), 32'h1 << (k % 4));
      check($sformatf("cont_addr_%0d", k), 32'(mem_addr_a), 32'h010 + (k % 4));
      if (k > 0) begin
        check($sformatf("cont_rsp_v_%0d", k), 32'(rsp_valid_a), 32'h1 << ((k - 1) % 4));
        check($sformatf("cont_rsp_d_%0d", k), rsp_data_a, 32'hC0DE0000 + ((k - 1) % 4));
      end
      cyc();
    end
    idle_all();
    #1;
    check("cont_rsp_v_last", 32'(rsp_valid_a), 32'h8);
    check("cont_rsp_d_last", rsp_data_a, 32'hC0DE0003);
    check("cont_idle_en", 32'(mem_en_a), 32'h0);

    // Single read by requester 1
    cyc();
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h040, '0);
    #1;
    check("rd_ready", 32'(ready_a), 32'h2);
    check("rd_mem_en", 32'(mem_en_a), 32'h1);
    check("rd_mem_addr", 32'(mem_addr_a), 32'h040);
    cyc();
    idle_all();
    #1;
    check("rd_rsp_valid", 32'(rsp_valid_a), 32'h2);
    check("rd_rsp_data", rsp_data_a, 32'hDEADBEEF);

    // Write by requester 2, then read back by requester 0
    cyc();
    set_req(2, 1'b1, 1'b1, 1'b0, 12'h300, 32'h12345678);
    #1;
    check("wr_ready", 32'(ready_a), 32'h4);
    check("wr_mem_we", 32'(mem_we_a), 32'h1);
    check("wr_mem_addr", 32'(mem_addr_a), 32'h300);
    check("wr_mem_wdata", mem_wdata_a, 32'h12345678);
    cyc();
    idle_all();
    #1;
    check("wr_no_rsp", 32'(rsp_valid_a), 32'h0);
    check("wr_idle_en", 32'(mem_en_a), 32'h0);
    check("wr_idle_we", 32'(mem_we_a), 32'h0);
    cyc();
    set_req(0, 1'b1, 1'b0, 1'b0, 12'h300, '0);
    #1;
    check("rb_ready", 32'(ready_a), 32'h1);
    cyc();
    idle_all();
    #1;
    check("rb_rsp_valid", 32'(rsp_valid_a), 32'h1);
    check("rb_rsp_data", rsp_data_a, 32'h12345678);

    // Lock burst: requester 1 holds four reads while requester 2 waits
    begin
      logic [AW-1:0] la [4];
      logic [DW-1:0] ld [4];
      la[0] = 12'h000; la[1] = 12'h001; la[2] = 12'h018; la[3] = 12'h019;
      ld[0] = 32'h11111111; ld[1] = 32'h22222222; ld[2] = 32'h33333333; ld[3] = 32'h44444444;
      cyc();
      set_req(2, 1'b1, 1'b0, 1'b0, 12'h040, '0);
      for (int k = 0; k < 4; k++) begin
        set_req(1, 1'b1, 1'b0, (k < 3), la[k], '0);
        #1;
        check($sformatf("lock_ready_%0d", k), 32'(ready_a), 32'h2);
        check($sformatf("lock_addr_%0d", k), 32'(mem_addr_a), 32'(la[k]));
        if (k > 0) check($sformatf("lock_rsp_d_%0d", k), rsp_data_a, ld[k-1]);
        cyc();
      end
      set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      check("lock_wait_grant", 32'(ready_a), 32'h4);
      check("lock_rsp_v_3", 32'(rsp_valid_a), 32'h2);
      check("lock_rsp_d_3", rsp_data_a, ld[3]);
      cyc();
      idle_all();
      #1;
      check("lock_rsp_v_r2", 32'(rsp_valid_a), 32'h4);
      check("lock_rsp_d_r2", rsp_data_a, 32'hDEADBEEF);
    end

    // Lock timeout on the MAX_LOCK=3 instance
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    set_req(3, 1'b1, 1'b0, 1'b1, 12'h020, '0);
    #1;
    check("tmo_ready_0", 32'(ready_t), 32'h8);
    cyc();
    set_req(0, 1'b1, 1'b0, 1'b0, 12'h021, '0);
    #1;
    check("tmo_ready_1", 32'(ready_t), 32'h8);
    check("tmo_rsp_v", 32'(rsp_valid_t), 32'h8);
    check("tmo_rsp_d", rsp_data_t, 32'hCAFEF00D);
    cyc();
    #1;
    check("tmo_ready_2", 32'(ready_t), 32'h8);
    cyc();
    #1;
    check("tmo_next_grant", 32'(ready_t), 32'h1);
    check("tmo_next_addr", 32'(mem_addr_t), 32'h021);
    cyc();
    idle_all();
    #1;
    check("tmo_idle_en", 32'(mem_en_a), 32'h0);

    // Reset the cycle after a read accept
    cyc();
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h040, '0);
    #1;
    check("mrst_accept", 32'(ready_a), 32'h2);
    cyc();
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("mrst_rsp_in_rst", 32'(rsp_valid_a), 32'h0);
    check("mrst_ready_in_rst", 32'(ready_a), 32'h0);
    check("mrst_en_in_rst", 32'(mem_en_a), 32'h0);
    cyc();
    reset = 1'b0;
    #1;
    check("mrst_rsp_after", 32'(rsp_valid_a), 32'h0);
    check("mrst_state", 32'(dut_a.state_q), 32'(ST_IDLE));
    check("mrst_ptr_zero", 32'(ready_a), 32'h1);
    cyc();
    idle_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
